inference_ctrl: RTL and testbench

Per-image sequencer between the pixel sorter, the off-block AER input link and the SNN output spike bus.
- Starts the sorter on START.
- Converts each sorted pixel index into a four-phase AER REQ/ACK transaction.
- Holds the sorter off via AERIN_CTRL_BUSY while a transaction is open.
- Terminates the inference on the first output-neuron spike, or after the image is fully encoded, and reports the winning class.

---
 rtl/inference_pkg.sv | 16 +
 rtl/inference_ctrl_if.sv | 22 ++
 rtl/aer_sync2.sv | 21 ++
 rtl/inference_ctrl.sv | 162 ++++++++++++++++
 tb/tb_inference_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inference_pkg.sv
// Shared types and defaults for the per-image inference sequencer.
package inference_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    REQ_HI,
    REQ_LO,
    DRAIN,
    FINISH
  } ctrl_state_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 8;
  localparam int unsigned ACK_TIMEOUT_DEF  = 1023;

endpackage

// File: rtl/inference_ctrl_if.sv
// Four-phase AER output link: address + REQ from the sequencer, ACK back from the off-block input.
interface inference_ctrl_if #(
  parameter int unsigned ADDR_W = 9
) ();

  logic [ADDR_W-1:0] AEROUT_ADDR;
  logic              AEROUT_REQ;
  logic              AEROUT_ACK;

  modport master (
    output AEROUT_ADDR,
    output AEROUT_REQ,
    input  AEROUT_ACK
  );

  modport slave (
    input  AEROUT_ADDR,
    input  AEROUT_REQ,
    output AEROUT_ACK
  );

endinterface

// File: rtl/aer_sync2.sv
// Two-flop synchroniser for the AER acknowledge, which arrives asynchronously to CLK.
module aer_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[0], async_i};
    end
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/inference_ctrl.sv
// Per-image sequencer: starts the sorter, turns sorted pixel indices into AER handshakes and
// stops the image on the first output spike (or once fully encoded), reporting the class.
module inference_ctrl
  import inference_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE      = 256,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned N_CLASSES       = 10,
  parameter int unsigned CLASS_BITS      = $clog2(N_CLASSES),
  parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
  parameter int unsigned DRAIN_CYCLES    = DRAIN_CYCLES_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     NEW_IMAGE,
  input  logic [IMAGE_SIZE_BITS:0] NEXT_INDEX,
  input  logic                     FOUND_NEXT_INDEX,
  input  logic                     IMAGE_ENCODED,
  output logic                     AERIN_CTRL_BUSY,
  output logic                     INFERENCE_DONE,
  input  logic                     SNN_SPIKE_VALID,
  input  logic [CLASS_BITS-1:0]    SNN_SPIKE_ID,
  output logic [CLASS_BITS-1:0]    RESULT,
  output logic                     RESULT_VALID,
  output logic                     RESULT_NONE,
  output logic                     TIMEOUT_ERR,
  inference_ctrl_if.master         aer
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_t              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IMAGE_SIZE_BITS:0] addr_q, addr_d;
  logic [CLASS_BITS-1:0]    result_q, result_d;
  logic                     won_q, won_d;
  logic                     none_q, none_d;
  logic                     tmo_q, tmo_d;
  logic                     busy_q, new_image_q, ctrl_busy_q, req_q, done_q, valid_q;
  logic                     ack_s;
  logic                     spike_new;
  logic                     timed_out;

  aer_sync2 u_ack_sync (
    .CLK     (CLK),
    .RST     (RST),
    .async_i (aer.AEROUT_ACK),
    .sync_o  (ack_s)
  );

  assign spike_new = SNN_SPIKE_VALID && !won_q;
  assign timed_out = (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    result_d = result_q;
    won_d    = won_q;
    none_d   = none_q;
    tmo_d    = tmo_q;

    // A spike during an open handshake is latched now; the handshake still completes.
    if ((state_q == STREAM || state_q == REQ_HI || state_q == REQ_LO) && spike_new) begin
      result_d = SNN_SPIKE_ID;
      won_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          none_d  = 1'b0;
          tmo_d   = 1'b0;
          won_d   = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (spike_new) begin
          state_d = DRAIN;
        end else if (IMAGE_ENCODED) begin
          none_d  = 1'b1;
          state_d = FINISH;
        end else if (FOUND_NEXT_INDEX) begin
          addr_d  = NEXT_INDEX;
          state_d = REQ_HI;
        end
      end
      REQ_HI, REQ_LO: begin
        if ((state_q == REQ_HI) && ack_s) begin
          state_d = REQ_LO;
        end else if ((state_q == REQ_LO) && !ack_s) begin
          state_d = won_d ? DRAIN : STREAM;
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          none_d  = !won_d;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One saturating counter serves both the ACK wait and the drain; it restarts on every state change.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      result_q    <= '0;
      won_q       <= 1'b0;
      none_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
      new_image_q <= 1'b0;
      ctrl_busy_q <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      result_q    <= result_d;
      won_q       <= won_d;
      none_q      <= none_d;
      tmo_q       <= tmo_d;
      busy_q      <= (state_d != IDLE);
      new_image_q <= (state_q == IDLE) && (state_d == STREAM);
      ctrl_busy_q <= (state_d == REQ_HI) || (state_d == REQ_LO);
      req_q       <= (state_d == REQ_HI);
      done_q      <= (state_d == DRAIN);
      valid_q     <= (state_d == FINISH);
    end
  end

  assign BUSY            = busy_q;
  assign NEW_IMAGE       = new_image_q;
  assign AERIN_CTRL_BUSY = ctrl_busy_q;
  assign INFERENCE_DONE  = done_q;
  assign RESULT          = result_q;
  assign RESULT_VALID    = valid_q;
  assign RESULT_NONE     = none_q;
  assign TIMEOUT_ERR     = tmo_q;
  assign aer.AEROUT_ADDR = addr_q;
  assign aer.AEROUT_REQ  = req_q;

endmodule

// File: tb/tb_inference_ctrl.sv
// Directed bench for inference_ctrl: table of image scenarios plus hand-written timeout and reset runs.
module tb_inference_ctrl;

  localparam int unsigned IW = 9;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          BUSY, NEW_IMAGE;
  logic [IW-1:0] NEXT_INDEX = '0;
  logic          FOUND_NEXT_INDEX = 1'b0;
  logic          IMAGE_ENCODED = 1'b0;
  logic          AERIN_CTRL_BUSY, INFERENCE_DONE;
  logic          SNN_SPIKE_VALID = 1'b0;
  logic [CW-1:0] SNN_SPIKE_ID = '0;
  logic [CW-1:0] RESULT;
  logic          RESULT_VALID, RESULT_NONE, TIMEOUT_ERR;

  inference_ctrl_if #(.ADDR_W(IW)) aer ();

  inference_ctrl dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .BUSY             (BUSY),
    .NEW_IMAGE        (NEW_IMAGE),
    .NEXT_INDEX       (NEXT_INDEX),
    .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
    .IMAGE_ENCODED    (IMAGE_ENCODED),
    .AERIN_CTRL_BUSY  (AERIN_CTRL_BUSY),
    .INFERENCE_DONE   (INFERENCE_DONE),
    .SNN_SPIKE_VALID  (SNN_SPIKE_VALID),
    .SNN_SPIKE_ID     (SNN_SPIKE_ID),
    .RESULT           (RESULT),
    .RESULT_VALID     (RESULT_VALID),
    .RESULT_NONE      (RESULT_NONE),
    .TIMEOUT_ERR      (TIMEOUT_ERR),
    .aer              (aer)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // mode: 0 encode end, 1 spike in STREAM, 2 spike+FOUND, 3 spike in REQ_HI of last index,
  //       4 spike+IMAGE_ENCODED
  typedef struct {
    int n_idx;
    int base;
    int mode;
    int spike_id;
    int exp_reqs;
    int exp_result;
    int exp_none;
    int exp_done;
  } vec_t;

  vec_t tbl[7];

  // Monitor: counts REQ rises and INFERENCE_DONE cycles, and flags handshake-integrity violations.
  int            req_rises = 0;
  int            done_cyc = 0;
  int            busy_viol = 0;
  int            addr_viol = 0;
  logic [IW-1:0] last_addr = '0;
  logic [IW-1:0] addr_prev = '0;
  logic          req_prev = 1'b0;
  logic          cb_prev = 1'b0;

  always @(posedge CLK) begin
    #2;
    if (!RST) begin
      if (aer.AEROUT_REQ && !req_prev) begin
        req_rises++;
        last_addr = aer.AEROUT_ADDR;
      end
      if (INFERENCE_DONE) done_cyc++;
      if (aer.AEROUT_REQ && !AERIN_CTRL_BUSY) busy_viol++;
      if (cb_prev && !AERIN_CTRL_BUSY && (aer.AEROUT_ACK || aer.AEROUT_REQ)) busy_viol++;
      if (cb_prev && AERIN_CTRL_BUSY && (aer.AEROUT_ADDR !== addr_prev)) addr_viol++;
    end
    req_prev  = aer.AEROUT_REQ;
    cb_prev   = AERIN_CTRL_BUSY;
    addr_prev = aer.AEROUT_ADDR;
  end

  // AER receiver model: ACK follows REQ after ack_delay cycles when enabled.
  int ack_delay = 3;
  bit ack_auto = 1'b1;
  int acnt = 0;

  always @(posedge CLK) begin
    #3;
    if (RST) begin
      aer.AEROUT_ACK = 1'b0;
      acnt = 0;
    end else if (ack_auto && (aer.AEROUT_REQ != aer.AEROUT_ACK)) begin
      acnt++;
      if (acnt >= ack_delay) begin
        aer.AEROUT_ACK = aer.AEROUT_REQ;
        acnt = 0;
      end
    end else begin
      acnt = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2ms", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int r0, d0, t;
    r0 = req_rises;
    d0 = done_cyc;
    START = 1'b1;
    tick();
    START = 1'b0;
    check($sformatf("v%0d_new_image", k), NEW_IMAGE, 1);
    check($sformatf("v%0d_busy_start", k), BUSY, 1);
    check($sformatf("v%0d_tmo_cleared", k), TIMEOUT_ERR, 0);
    for (int i = 0; i < v.n_idx; i++) begin
      FOUND_NEXT_INDEX = 1'b1;
      NEXT_INDEX = IW'(v.base + i);
      tick();
      FOUND_NEXT_INDEX = 1'b0;
      if (i == 0) check($sformatf("v%0d_ctrl_busy_found1", k), AERIN_CTRL_BUSY, 1);
      if (v.mode == 3 && i == v.n_idx - 1) begin
        SNN_SPIKE_VALID = 1'b1;
        SNN_SPIKE_ID = CW'(v.spike_id);
        tick();
        SNN_SPIKE_VALID = 1'b0;
      end
      t = 0;
      while (AERIN_CTRL_BUSY && t < 200) begin
        tick();
        t++;
      end
      if (AERIN_CTRL_BUSY) begin
        check($sformatf("v%0d_handshake_%0d_done", k, i), AERIN_CTRL_BUSY, 0);
        return;
      end
    end
    case (v.mode)
      0: IMAGE_ENCODED = 1'b1;
      1: SNN_SPIKE_VALID = 1'b1;
      2: begin
        SNN_SPIKE_VALID = 1'b1;
        FOUND_NEXT_INDEX = 1'b1;
        NEXT_INDEX = IW'(v.base + v.n_idx);
      end
      4: begin
        SNN_SPIKE_VALID = 1'b1;
        IMAGE_ENCODED = 1'b1;
      end
      default: ;
    endcase
    SNN_SPIKE_ID = CW'(v.spike_id);
    if (v.mode != 3) tick();
    IMAGE_ENCODED = 1'b0;
    SNN_SPIKE_VALID = 1'b0;
    FOUND_NEXT_INDEX = 1'b0;
    if (v.mode != 0) begin
      // In DRAIN the sorter's strobes must be ignored.
      check($sformatf("v%0d_drain_entered", k), INFERENCE_DONE, 1);
      FOUND_NEXT_INDEX = 1'b1;
      IMAGE_ENCODED = 1'b1;
      NEXT_INDEX = IW'(1);
      tick();
      FOUND_NEXT_INDEX = 1'b0;
      IMAGE_ENCODED = 1'b0;
    end
    t = 0;
    while (!RESULT_VALID && t < 100) begin
      tick();
      t++;
    end
    check($sformatf("v%0d_result_valid", k), RESULT_VALID, 1);
    check($sformatf("v%0d_result_none", k), RESULT_NONE, v.exp_none);
    if (v.exp_none == 0) check($sformatf("v%0d_result", k), RESULT, v.exp_result);
    check($sformatf("v%0d_timeout_err", k), TIMEOUT_ERR, 0);
    if (v.exp_reqs > 0) check($sformatf("v%0d_last_addr", k), last_addr, v.base + v.exp_reqs - 1);
    tick();
    check($sformatf("v%0d_valid_pulse", k), RESULT_VALID, 0);
    check($sformatf("v%0d_busy_end", k), BUSY, 0);
    check($sformatf("v%0d_req_count", k), req_rises - r0, v.exp_reqs);
    check($sformatf("v%0d_done_cycles", k), done_cyc - d0, v.exp_done);
  endtask

  initial begin
    int t;
    tbl[0] = '{1, 37, 0, 0, 1, 0, 1, 0};
    tbl[1] = '{3, 100, 3, 7, 3, 7, 0, 8};
    tbl[2] = '{2, 10, 2, 3, 2, 3, 0, 8};
    tbl[3] = '{0, 0, 1, 9, 0, 9, 0, 8};
    tbl[4] = '{1, 500, 4, 5, 1, 5, 0, 8};
    tbl[5] = '{256, 0, 0, 0, 256, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 0};

    repeat (3) tick();
    check("rst_busy", BUSY, 0);
    check("rst_new_image", NEW_IMAGE, 0);
    check("rst_ctrl_busy", AERIN_CTRL_BUSY, 0);
    check("rst_done", INFERENCE_DONE, 0);
    check("rst_req", aer.AEROUT_REQ, 0);
    check("rst_addr", aer.AEROUT_ADDR, 0);
    check("rst_result", RESULT, 0);
    check("rst_valid", RESULT_VALID, 0);
    check("rst_none", RESULT_NONE, 0);
    check("rst_tmo", TIMEOUT_ERR, 0);
    RST = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], i);
      repeat (2) tick();
    end

    // ACK stuck low: the open REQ must time out after ~ACK_TIMEOUT cycles.
    ack_auto = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    FOUND_NEXT_INDEX = 1'b1;
    NEXT_INDEX = IW'(77);
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    check("tmo_req_high", aer.AEROUT_REQ, 1);
    t = 0;
    while (!TIMEOUT_ERR && t < 1100) begin
      tick();
      t++;
    end
    check("tmo_set", TIMEOUT_ERR, 1);
    check("tmo_latency_in_window", (t >= 1010 && t <= 1030), 1);
    check("tmo_req_dropped", aer.AEROUT_REQ, 0);
    check("tmo_ctrl_busy_dropped", AERIN_CTRL_BUSY, 0);
    check("tmo_drain", INFERENCE_DONE, 1);
    t = 0;
    while (!RESULT_VALID && t < 50) begin
      tick();
      t++;
    end
    check("tmo_result_valid", RESULT_VALID, 1);
    check("tmo_result_none", RESULT_NONE, 1);
    tick();
    check("tmo_sticky", TIMEOUT_ERR, 1);
    check("tmo_busy_end", BUSY, 0);
    ack_auto = 1'b1;
    run_vec(tbl[6], 7);
    repeat (2) tick();

    // Reset in REQ_HI drops everything at once; a fresh image must then run normally.
    ack_delay = 40;
    START = 1'b1;
    tick();
    START = 1'b0;
    FOUND_NEXT_INDEX = 1'b1;
    NEXT_INDEX = IW'(55);
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    tick();
    check("rstmid_req_before", aer.AEROUT_REQ, 1);
    RST = 1'b1;
    #1;
    check("rstmid_req", aer.AEROUT_REQ, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_ctrl_busy", AERIN_CTRL_BUSY, 0);
    check("rstmid_done", INFERENCE_DONE, 0);
    repeat (2) tick();
    RST = 1'b0;
    ack_delay = 3;
    repeat (2) tick();
    run_vec(tbl[0], 8);

    check("mon_busy_covers_req", busy_viol, 0);
    check("mon_addr_stable", addr_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
